id_stage: RTL and testbench

Instruction decode stage of the 5-stage RV32I pipeline. Consumes the instruction word and PC from the fetch stage, decodes the RV32I base set, reads the 32×32 integer register file, generates immediates, and detects load-use hazards (stall_ld / stall_ld_ex back to fetch). All results are registered into the ID/EX pipeline register feeding the execute stage; the register file is written from the write-back stage.

---
 rtl/id_stage.sv | 209 ++++++++++++++++++++
 tb/tb_id_stage.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// RV32I instruction decode stage: decoder, immediate generator, 32x32 register
// file with write-through bypass, load-use hazard detection and the ID/EX register.
module id_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_id,
    input  logic [29:0] pc_id,
    input  logic        stall,
    input  logic        rst_pipe,
    input  logic        wbk_en_wb,
    input  logic [4:0]  rd_adr_wb,
    input  logic [31:0] wbk_data_wb,
    output logic        stall_ld,
    output logic        stall_ld_ex,
    output logic [29:0] pc_ex,
    output logic [31:0] rs1_data_ex,
    output logic [31:0] rs2_data_ex,
    output logic [4:0]  rs1_adr_ex,
    output logic [4:0]  rs2_adr_ex,
    output logic [4:0]  rd_adr_ex,
    output logic [31:0] imm_ex,
    output logic [2:0]  funct3_ex,
    output logic        funct7b5_ex,
    output logic        cmd_lui_ex,
    output logic        cmd_auipc_ex,
    output logic        cmd_jal_ex,
    output logic        cmd_jalr_ex,
    output logic        cmd_br_ex,
    output logic        cmd_ld_ex,
    output logic        cmd_st_ex,
    output logic        cmd_alui_ex,
    output logic        cmd_alu_ex,
    output logic        cmd_ecall_ex,
    output logic        wbk_en_ex
);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_ALUI  = 7'b0010011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    typedef struct packed {
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [4:0]  rs1_adr;
        logic [4:0]  rs2_adr;
        logic [4:0]  rd_adr;
        logic [31:0] imm;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic        lui;
        logic        auipc;
        logic        jal;
        logic        jalr;
        logic        br;
        logic        ld;
        logic        st;
        logic        alui;
        logic        alu;
        logic        ecall;
        logic        wbk_en;
    } idex_t;

    logic [31:0] r_rf [32];
    idex_t       r_idex;
    logic [29:0] r_pc;
    logic        r_stall_ld_ex;

    logic [6:0]  w_op;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic        w_rs1_used;
    logic        w_rs2_used;
    logic [31:0] w_rs1_data;
    logic [31:0] w_rs2_data;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic        w_stall_ld;
    idex_t       w_dec;

    assign w_op  = inst_id[6:0];
    assign w_rs1 = inst_id[19:15];
    assign w_rs2 = inst_id[24:20];
    assign w_rd  = inst_id[11:7];

    assign w_imm_i = {{20{inst_id[31]}}, inst_id[31:20]};
    assign w_imm_s = {{20{inst_id[31]}}, inst_id[31:25], inst_id[11:7]};
    assign w_imm_b = {{19{inst_id[31]}}, inst_id[31], inst_id[7], inst_id[30:25], inst_id[11:8], 1'b0};
    assign w_imm_u = {inst_id[31:12], 12'd0};
    assign w_imm_j = {{11{inst_id[31]}}, inst_id[31], inst_id[19:12], inst_id[20], inst_id[30:21], 1'b0};

    // Write-through bypass: a register written this cycle is read with its new value.
    always_comb begin
        w_rs1_data = r_rf[w_rs1];
        if (w_rs1 == 5'd0)
            w_rs1_data = 32'd0;
        else if (wbk_en_wb && (rd_adr_wb == w_rs1))
            w_rs1_data = wbk_data_wb;
    end

    always_comb begin
        w_rs2_data = r_rf[w_rs2];
        if (w_rs2 == 5'd0)
            w_rs2_data = 32'd0;
        else if (wbk_en_wb && (rd_adr_wb == w_rs2))
            w_rs2_data = wbk_data_wb;
    end

    always_comb begin
        w_dec          = '0;
        w_dec.lui      = (w_op == OP_LUI);
        w_dec.auipc    = (w_op == OP_AUIPC);
        w_dec.jal      = (w_op == OP_JAL);
        w_dec.jalr     = (w_op == OP_JALR);
        w_dec.br       = (w_op == OP_BR);
        w_dec.ld       = (w_op == OP_LD);
        w_dec.st       = (w_op == OP_ST);
        w_dec.alui     = (w_op == OP_ALUI);
        w_dec.alu      = (w_op == OP_ALU);
        w_dec.ecall    = (w_op == OP_SYS) && (inst_id[31:7] == 25'd0);
        w_dec.rs1_adr  = w_rs1;
        w_dec.rs2_adr  = w_rs2;
        w_dec.rd_adr   = w_rd;
        w_dec.rs1_data = w_rs1_data;
        w_dec.rs2_data = w_rs2_data;
        w_dec.funct3   = inst_id[14:12];
        w_dec.funct7b5 = inst_id[30];
        w_dec.wbk_en   = (w_dec.lui | w_dec.auipc | w_dec.jal | w_dec.jalr |
                          w_dec.ld | w_dec.alui | w_dec.alu) && (w_rd != 5'd0);
        if (w_dec.jalr || w_dec.ld || w_dec.alui)
            w_dec.imm = w_imm_i;
        else if (w_dec.st)
            w_dec.imm = w_imm_s;
        else if (w_dec.br)
            w_dec.imm = w_imm_b;
        else if (w_dec.lui || w_dec.auipc)
            w_dec.imm = w_imm_u;
        else if (w_dec.jal)
            w_dec.imm = w_imm_j;
    end

    assign w_rs1_used = w_dec.jalr | w_dec.br | w_dec.ld | w_dec.st | w_dec.alui | w_dec.alu;
    assign w_rs2_used = w_dec.br | w_dec.st | w_dec.alu;

    // A flush discards the consumer anyway, so it suppresses the hazard.
    assign w_stall_ld = r_idex.ld && (r_idex.rd_adr != 5'd0) &&
                        ((w_rs1_used && (w_rs1 == r_idex.rd_adr)) ||
                         (w_rs2_used && (w_rs2 == r_idex.rd_adr))) &&
                        !rst_pipe;

    always_ff @(posedge clk) begin
        if (wbk_en_wb && (rd_adr_wb != 5'd0))
            r_rf[rd_adr_wb] <= wbk_data_wb;
    end

    // ID/EX register: bubbles keep the previous PC so the EX stage still has a sane value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idex        <= '0;
            r_pc          <= 30'd0;
            r_stall_ld_ex <= 1'b0;
        end else if (rst_pipe) begin
            r_idex        <= '0;
            r_stall_ld_ex <= 1'b0;
        end else if (!stall) begin
            r_stall_ld_ex <= w_stall_ld;
            if (w_stall_ld) begin
                r_idex <= '0;
            end else begin
                r_idex <= w_dec;
                r_pc   <= pc_id;
            end
        end
    end

    assign stall_ld     = w_stall_ld;
    assign stall_ld_ex  = r_stall_ld_ex;
    assign pc_ex        = r_pc;
    assign rs1_data_ex  = r_idex.rs1_data;
    assign rs2_data_ex  = r_idex.rs2_data;
    assign rs1_adr_ex   = r_idex.rs1_adr;
    assign rs2_adr_ex   = r_idex.rs2_adr;
    assign rd_adr_ex    = r_idex.rd_adr;
    assign imm_ex       = r_idex.imm;
    assign funct3_ex    = r_idex.funct3;
    assign funct7b5_ex  = r_idex.funct7b5;
    assign cmd_lui_ex   = r_idex.lui;
    assign cmd_auipc_ex = r_idex.auipc;
    assign cmd_jal_ex   = r_idex.jal;
    assign cmd_jalr_ex  = r_idex.jalr;
    assign cmd_br_ex    = r_idex.br;
    assign cmd_ld_ex    = r_idex.ld;
    assign cmd_st_ex    = r_idex.st;
    assign cmd_alui_ex  = r_idex.alui;
    assign cmd_alu_ex   = r_idex.alu;
    assign cmd_ecall_ex = r_idex.ecall;
    assign wbk_en_ex    = r_idex.wbk_en;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: decode table, hand-written hazard/flush/stall sequences and
// randomized traffic checked against a cycle-level reference model.
module tb_id_stage;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_ALUI  = 7'b0010011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;
    localparam logic [6:0] OP_SYS   = 7'b1110011;
    localparam logic [6:0] OP_FENCE = 7'b0001111;

    // cmd vector bit order {lui,auipc,jal,jalr,br,ld,st,alui,alu,ecall}
    localparam logic [9:0] K_LUI = 10'h200, K_AUIPC = 10'h100, K_JAL = 10'h080, K_JALR = 10'h040,
                           K_BR = 10'h020, K_LD = 10'h010, K_ST = 10'h008, K_ALUI = 10'h004,
                           K_ALU = 10'h002, K_ECALL = 10'h001, K_NONE = 10'h000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst_id = 32'd0;
    logic [29:0] pc_id = 30'd0;
    logic        stall = 1'b0;
    logic        rst_pipe = 1'b0;
    logic        wbk_en_wb = 1'b0;
    logic [4:0]  rd_adr_wb = 5'd0;
    logic [31:0] wbk_data_wb = 32'd0;
    logic        stall_ld, stall_ld_ex;
    logic [29:0] pc_ex;
    logic [31:0] rs1_data_ex, rs2_data_ex, imm_ex;
    logic [4:0]  rs1_adr_ex, rs2_adr_ex, rd_adr_ex;
    logic [2:0]  funct3_ex;
    logic        funct7b5_ex, wbk_en_ex;
    logic        cmd_lui_ex, cmd_auipc_ex, cmd_jal_ex, cmd_jalr_ex, cmd_br_ex;
    logic        cmd_ld_ex, cmd_st_ex, cmd_alui_ex, cmd_alu_ex, cmd_ecall_ex;
    logic [9:0]  cmd_vec;

    assign cmd_vec = {cmd_lui_ex, cmd_auipc_ex, cmd_jal_ex, cmd_jalr_ex, cmd_br_ex,
                      cmd_ld_ex, cmd_st_ex, cmd_alui_ex, cmd_alu_ex, cmd_ecall_ex};

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .rst_n(rst_n), .inst_id(inst_id), .pc_id(pc_id), .stall(stall),
        .rst_pipe(rst_pipe), .wbk_en_wb(wbk_en_wb), .rd_adr_wb(rd_adr_wb), .wbk_data_wb(wbk_data_wb),
        .stall_ld(stall_ld), .stall_ld_ex(stall_ld_ex), .pc_ex(pc_ex),
        .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex),
        .rs1_adr_ex(rs1_adr_ex), .rs2_adr_ex(rs2_adr_ex), .rd_adr_ex(rd_adr_ex),
        .imm_ex(imm_ex), .funct3_ex(funct3_ex), .funct7b5_ex(funct7b5_ex),
        .cmd_lui_ex(cmd_lui_ex), .cmd_auipc_ex(cmd_auipc_ex), .cmd_jal_ex(cmd_jal_ex),
        .cmd_jalr_ex(cmd_jalr_ex), .cmd_br_ex(cmd_br_ex), .cmd_ld_ex(cmd_ld_ex),
        .cmd_st_ex(cmd_st_ex), .cmd_alui_ex(cmd_alui_ex), .cmd_alu_ex(cmd_alu_ex),
        .cmd_ecall_ex(cmd_ecall_ex), .wbk_en_ex(wbk_en_ex)
    );

    typedef struct packed {
        logic [29:0] pc;
        logic [31:0] r1d;
        logic [31:0] r2d;
        logic [4:0]  r1a;
        logic [4:0]  r2a;
        logic [4:0]  rda;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic        f7;
        logic [9:0]  cmd;
        logic        wbk;
        logic        sldx;
    } ex_t;

    typedef struct {
        logic [31:0] ins;
        logic [9:0]  cmd;
        logic [31:0] imm;
        logic        wbk;
        logic [4:0]  rd;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    ex_t         m_ex = '0;
    logic [31:0] m_rf [32];
    bit          known = 1'b0;
    logic        obs_sld = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    // Reference decode: instruction class from the opcode, immediates by signed arithmetic.
    function automatic ex_t model_decode(input logic [31:0] ins);
        ex_t e;
        logic signed [31:0] s;
        logic [31:0] sgn;
        logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
        e = '0;
        s = ins;
        sgn = 32'(s >>> 31);
        imm_i = 32'(s >>> 20);
        imm_s = (32'(s >>> 25) << 5) | 32'(ins[11:7]);
        imm_b = (sgn << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
        imm_u = ins & 32'hFFFF_F000;
        imm_j = (sgn << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
        case (ins[6:0])
            OP_LUI:   begin e.cmd = K_LUI;   e.imm = imm_u; end
            OP_AUIPC: begin e.cmd = K_AUIPC; e.imm = imm_u; end
            OP_JAL:   begin e.cmd = K_JAL;   e.imm = imm_j; end
            OP_JALR:  begin e.cmd = K_JALR;  e.imm = imm_i; end
            OP_BR:    begin e.cmd = K_BR;    e.imm = imm_b; end
            OP_LD:    begin e.cmd = K_LD;    e.imm = imm_i; end
            OP_ST:    begin e.cmd = K_ST;    e.imm = imm_s; end
            OP_ALUI:  begin e.cmd = K_ALUI;  e.imm = imm_i; end
            OP_ALU:   begin e.cmd = K_ALU;   e.imm = 32'd0; end
            OP_SYS:   e.cmd = (ins[31:7] == 25'd0) ? K_ECALL : K_NONE;
            default:  e.cmd = K_NONE;
        endcase
        e.r1a = ins[19:15];
        e.r2a = ins[24:20];
        e.rda = ins[11:7];
        e.f3  = ins[14:12];
        e.f7  = ins[30];
        e.wbk = ((e.cmd & (K_LUI | K_AUIPC | K_JAL | K_JALR | K_LD | K_ALUI | K_ALU)) != 10'd0) &&
                (e.rda != 5'd0);
        return e;
    endfunction

    function automatic logic [31:0] rf_read(input logic [4:0] a, input logic we,
                                            input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (we && wa == a) return wd;
        return m_rf[a];
    endfunction

    // One clock: drive inputs, check the combinational hazard, clock, check the ID/EX register.
    task automatic cycle(input logic rn, input logic [31:0] ins, input logic st, input logic rp,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        ex_t dec, nxt;
        logic haz, u1, u2;
        logic [29:0] pcv;
        pcv = 30'($urandom);
        rst_n = rn; inst_id = ins; pc_id = pcv; stall = st; rst_pipe = rp;
        wbk_en_wb = we; rd_adr_wb = wa; wbk_data_wb = wd;
        dec = model_decode(ins);
        u1 = (dec.cmd & (K_JALR | K_BR | K_LD | K_ST | K_ALUI | K_ALU)) != 10'd0;
        u2 = (dec.cmd & (K_BR | K_ST | K_ALU)) != 10'd0;
        haz = ((m_ex.cmd & K_LD) != 10'd0) && (m_ex.rda != 5'd0) &&
              ((u1 && ins[19:15] == m_ex.rda) || (u2 && ins[24:20] == m_ex.rda)) && !rp;
        @(negedge clk);
        obs_sld = stall_ld;
        if (known) chk("stall_ld", 32'(stall_ld), 32'(haz));
        dec.r1d = rf_read(ins[19:15], we, wa, wd);
        dec.r2d = rf_read(ins[24:20], we, wa, wd);
        dec.pc  = pcv;
        nxt = m_ex;
        if (!rn) begin
            nxt = '0;
        end else if (rp) begin
            nxt = '0;
            nxt.pc = m_ex.pc;
        end else if (!st) begin
            if (haz) begin
                nxt = '0;
                nxt.pc = m_ex.pc;
                nxt.sldx = 1'b1;
            end else begin
                nxt = dec;
            end
        end
        @(posedge clk);
        #1;
        if (we && wa != 5'd0) m_rf[wa] = wd;
        m_ex = nxt;
        if (!rn) known = 1'b1;
        if (known) begin
            chk("pc_ex", 32'(pc_ex), 32'(m_ex.pc));
            chk("rs1_data_ex", rs1_data_ex, m_ex.r1d);
            chk("rs2_data_ex", rs2_data_ex, m_ex.r2d);
            chk("rs1_adr_ex", 32'(rs1_adr_ex), 32'(m_ex.r1a));
            chk("rs2_adr_ex", 32'(rs2_adr_ex), 32'(m_ex.r2a));
            chk("rd_adr_ex", 32'(rd_adr_ex), 32'(m_ex.rda));
            chk("imm_ex", imm_ex, m_ex.imm);
            chk("funct3_ex", 32'(funct3_ex), 32'(m_ex.f3));
            chk("funct7b5_ex", 32'(funct7b5_ex), 32'(m_ex.f7));
            chk("cmd_ex", 32'(cmd_vec), 32'(m_ex.cmd));
            chk("wbk_en_ex", 32'(wbk_en_ex), 32'(m_ex.wbk));
            chk("stall_ld_ex", 32'(stall_ld_ex), 32'(m_ex.sldx));
        end
    endtask

    task automatic run(input logic [31:0] ins);
        cycle(1'b1, ins, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    endtask

    vec_t vt [15];

    initial begin
        logic [31:0] lw7, add_dep, add_nodep, lw0, add_x0;
        logic [31:0] ins;
        logic [6:0]  ops [12];
        logic        st, rp, rn, we;

        vt[0]  = '{32'hFFF0_0293, K_ALUI,  32'hFFFF_FFFF, 1'b1, 5'd5};   // addi x5,x0,-1
        vt[1]  = '{32'hFE20_8EE3, K_BR,    32'hFFFF_FFFC, 1'b0, 5'd29};  // beq x1,x2,-4
        vt[2]  = '{32'h1234_5537, K_LUI,   32'h1234_5000, 1'b1, 5'd10};  // lui x10,0x12345
        vt[3]  = '{32'hFFFF_F097, K_AUIPC, 32'hFFFF_F000, 1'b1, 5'd1};   // auipc x1,0xfffff
        vt[4]  = '{32'hFF9F_F0EF, K_JAL,   32'hFFFF_FFF8, 1'b1, 5'd1};   // jal x1,-8
        vt[5]  = '{32'h0040_8067, K_JALR,  32'h0000_0004, 1'b0, 5'd0};   // jalr x0,4(x1)
        vt[6]  = '{32'hFF01_2383, K_LD,    32'hFFFF_FFF0, 1'b1, 5'd7};   // lw x7,-16(x2)
        vt[7]  = '{32'h0051_2423, K_ST,    32'h0000_0008, 1'b0, 5'd8};   // sw x5,8(x2)
        vt[8]  = '{32'h8000_0023, K_ST,    32'hFFFF_F800, 1'b0, 5'd0};   // sb x0,-2048(x0)
        vt[9]  = '{32'h0023_8433, K_ALU,   32'h0000_0000, 1'b1, 5'd8};   // add x8,x7,x2
        vt[10] = '{32'h4010_8033, K_ALU,   32'h0000_0000, 1'b0, 5'd0};   // sub x0,x1,x1
        vt[11] = '{32'h0000_0073, K_ECALL, 32'h0000_0000, 1'b0, 5'd0};   // ecall
        vt[12] = '{32'h0010_0073, K_NONE,  32'h0000_0000, 1'b0, 5'd0};   // ebreak
        vt[13] = '{32'h0FF0_000F, K_NONE,  32'h0000_0000, 1'b0, 5'd0};   // fence
        vt[14] = '{32'hFFFF_FFFF, K_NONE,  32'h0000_0000, 1'b0, 5'd31};  // illegal

        // Reset with random instructions
        cycle(1'b0, $urandom, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle(1'b0, $urandom, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("reset cmd", 32'(cmd_vec), 32'd0);
        chk("reset imm", imm_ex, 32'd0);
        chk("reset pc", 32'(pc_ex), 32'd0);
        chk("reset stall_ld", 32'(stall_ld), 32'd0);
        chk("reset stall_ld_ex", 32'(stall_ld_ex), 32'd0);

        // Give every register a known value
        for (int i = 1; i < 32; i++)
            cycle(1'b1, 32'd0, 1'b0, 1'b0, 1'b1, 5'(i), $urandom);

        // Decode table
        for (int i = 0; i < 15; i++) begin
            run(32'd0);
            run(vt[i].ins);
            chk($sformatf("tbl%0d cmd", i), 32'(cmd_vec), 32'(vt[i].cmd));
            chk($sformatf("tbl%0d imm", i), imm_ex, vt[i].imm);
            chk($sformatf("tbl%0d wbk", i), 32'(wbk_en_ex), 32'(vt[i].wbk));
            chk($sformatf("tbl%0d rd", i), 32'(rd_adr_ex), 32'(vt[i].rd));
        end

        // Register file: write-through bypass and x0
        cycle(1'b1, enc_r(7'd0, 5'd3, 5'd3, 3'd0, 5'd4, OP_ALU), 1'b0, 1'b0, 1'b1, 5'd3, 32'h1234_5678);
        chk("bypass rs1", rs1_data_ex, 32'h1234_5678);
        chk("bypass rs2", rs2_data_ex, 32'h1234_5678);
        run(enc_r(7'd0, 5'd0, 5'd3, 3'd0, 5'd5, OP_ALU));
        chk("x3 stored", rs1_data_ex, 32'h1234_5678);
        cycle(1'b1, enc_r(7'd0, 5'd0, 5'd0, 3'd0, 5'd4, OP_ALU), 1'b0, 1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF);
        chk("x0 bypass", rs1_data_ex, 32'd0);
        run(enc_r(7'd0, 5'd0, 5'd0, 3'd0, 5'd4, OP_ALU));
        chk("x0 read", rs2_data_ex, 32'd0);

        // Load-use hazard
        lw7       = enc_i(12'd0, 5'd1, 3'd2, 5'd7, OP_LD);
        add_dep   = enc_r(7'd0, 5'd2, 5'd7, 3'd0, 5'd8, OP_ALU);
        add_nodep = enc_r(7'd0, 5'd0, 5'd2, 3'd0, 5'd8, OP_ALU);
        lw0       = enc_i(12'd0, 5'd1, 3'd2, 5'd0, OP_LD);
        add_x0    = enc_r(7'd0, 5'd0, 5'd0, 3'd0, 5'd8, OP_ALU);
        run(lw7);
        run(add_dep);
        chk("lu stall_ld", 32'(obs_sld), 32'd1);
        chk("lu bubble", 32'(cmd_vec), 32'd0);
        chk("lu stall_ld_ex", 32'(stall_ld_ex), 32'd1);
        run(add_dep);
        chk("lu resume stall_ld", 32'(obs_sld), 32'd0);
        chk("lu resume alu", 32'(cmd_alu_ex), 32'd1);
        chk("lu resume rs1", 32'(rs1_adr_ex), 32'd7);
        chk("lu resume stall_ld_ex", 32'(stall_ld_ex), 32'd0);
        run(lw7);
        run(add_nodep);
        chk("nodep stall_ld", 32'(obs_sld), 32'd0);
        chk("nodep alu", 32'(cmd_alu_ex), 32'd1);
        run(lw0);
        run(add_x0);
        chk("x0 load stall_ld", 32'(obs_sld), 32'd0);

        // Flush wins over stall and hazard
        run(lw7);
        cycle(1'b1, add_dep, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
        chk("flush stall_ld", 32'(obs_sld), 32'd0);
        chk("flush bubble", 32'(cmd_vec), 32'd0);
        chk("flush wbk", 32'(wbk_en_ex), 32'd0);

        // Stall with hazard: hold, hazard persists
        run(lw7);
        cycle(1'b1, add_dep, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("stall+haz stall_ld", 32'(obs_sld), 32'd1);
        chk("stall+haz hold ld", 32'(cmd_ld_ex), 32'd1);
        run(add_dep);
        chk("stall+haz release", 32'(obs_sld), 32'd1);
        run(add_dep);
        chk("stall+haz alu", 32'(cmd_alu_ex), 32'd1);

        // Stall hold for three cycles
        run(32'hFFF0_0293);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'hFE20_8EE3, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
            chk("hold alui", 32'(cmd_alui_ex), 32'd1);
            chk("hold imm", imm_ex, 32'hFFFF_FFFF);
            chk("hold rd", 32'(rd_adr_ex), 32'd5);
        end
        run(32'hFE20_8EE3);
        chk("release br", 32'(cmd_br_ex), 32'd1);
        chk("release imm", imm_ex, 32'hFFFF_FFFC);

        // Randomized traffic against the model
        ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LD, OP_ST, OP_ALUI,
                OP_ALU, OP_SYS, OP_FENCE, 7'b1111111};
        ins = 32'd0;
        for (int n = 0; n < 1500; n++) begin
            if (!(obs_sld && $urandom_range(0, 3) != 0)) begin
                ins = $urandom;
                ins[6:0]   = ops[$urandom_range(0, 11)];
                if ($urandom_range(0, 3) == 0) ins[6:0] = OP_LD;
                ins[11:7]  = 5'($urandom_range(0, 3));
                ins[19:15] = 5'($urandom_range(0, 3));
                ins[24:20] = 5'($urandom_range(0, 3));
                if (ins[6:0] == OP_SYS && $urandom_range(0, 1) == 1) ins = 32'h0000_0073;
            end
            st = ($urandom_range(0, 5) == 0);
            rp = ($urandom_range(0, 9) == 0);
            rn = ($urandom_range(0, 199) != 0);
            we = $urandom_range(0, 1) == 1;
            cycle(rn, ins, st, rp, we, 5'($urandom_range(0, 4)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
